// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Groups the signals of the fetch stage that face the rest of the core:
//   the instruction-memory address/data pair, the redirect request from
//   execute, the valid/ready fetch output to decode, and the halted/fault
//   status flags.
//
//   Signals
//     imem_addr      fetch -> imem    byte address (the PC)
//     imem_data      imem  -> fetch   word at imem_addr, combinational
//     redirect_valid exec  -> fetch   request a PC change this cycle
//     redirect_pc    exec  -> fetch   redirect target byte address
//     out_valid      fetch -> decode  fetch buffer head is valid
//     out_ready      decode-> fetch   decode accepts the head this cycle
//     out_instr      fetch -> decode  instruction at buffer head
//     out_pc         fetch -> decode  PC of instruction at buffer head
//     halted         fetch -> env     PC ran past the end of memory
//     fault          fetch -> env     misaligned redirect seen (sticky)
//
//   Modports
//     master : the fetch unit itself
//     slave  : the environment (memory, execute, decode)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        fault;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output halted,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  halted,
        input  fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Program counter and fetch stage directly upstream of instruction memory.
//   The PC register drives the memory byte address; the returned word is
//   captured together with its PC into a 2-entry FIFO that feeds decode over
//   a valid/ready handshake. Execute can redirect the PC; a misaligned
//   redirect target parks the unit in a sticky FAULT state until reset.
//
//   Parameters
//     RESET_PC    PC loaded on reset
//     IMEM_WORDS  memory depth in 32-bit words; fetching past it halts
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     bus    master modport of instr_fetch_unit_if (memory, redirect,
//            decode handshake, halted/fault status)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_fetch_unit_if.master     bus
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic        rd_ptr;
    logic        rd_ptr_nxt;
    logic        wr_ptr;
    logic        wr_ptr_nxt;

    logic [31:0] buf_pc    [2];
    logic [31:0] buf_instr [2];

    logic        out_valid;
    logic        in_range;
    logic        pop;
    logic        room;
    logic        push;
    logic        flush;
    logic        redirect_ok;

    // Word index compared in 32 bits so large IMEM_WORDS values still work.
    assign in_range    = {2'b00, pc[31:2]} < IMEM_LIMIT;
    assign redirect_ok = (bus.redirect_pc[1:0] == 2'b00);

    // In FAULT the buffer is already flushed, but gate anyway so the head can
    // never leak out while faulted.
    assign out_valid = (state != ST_FAULT) && (count != 2'd0);
    assign pop       = out_valid && bus.out_ready;

    // A full buffer still has room when its head leaves in the same cycle.
    assign room      = (count != 2'd2) || pop;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            pc     <= RESET_PC;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            count  <= count_nxt;
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
        end
    end

    // Next-state logic: redirect beats fetch; run-off moves to HALT.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        flush     = 1'b0;

        case (state)
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_ok) begin
                        pc_nxt    = bus.redirect_pc;
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_FAULT;
                    end
                end else if (!in_range) begin
                    state_nxt = ST_HALT;
                end else if (room) begin
                    push   = 1'b1;
                    pc_nxt = pc + 32'd4;
                end
            end
            ST_HALT: begin
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_ok) begin
                        pc_nxt    = bus.redirect_pc;
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_FAULT;
            end
        endcase
    end

    // FIFO occupancy and pointers. A flush wins over any same-cycle pop;
    // the popped entry has already been handed to decode.
    always_comb begin
        count_nxt  = count;
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;

        if (flush) begin
            count_nxt  = 2'd0;
            rd_ptr_nxt = 1'b0;
            wr_ptr_nxt = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_nxt = ~wr_ptr;
            end
            if (pop) begin
                rd_ptr_nxt = ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_nxt = count + 2'd1;
                2'b01:   count_nxt = count - 2'd1;
                default: count_nxt = count;
            endcase
        end
    end

    // Buffer storage: data only, qualified by count, so no reset needed.
    // When full with a pop, wr_ptr equals rd_ptr and the write lands in the
    // slot being read out this same cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= pc;
            buf_instr[wr_ptr] <= bus.imem_data;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = buf_pc[rd_ptr];
    assign bus.out_instr = buf_instr[rd_ptr];
    assign bus.halted    = (state == ST_HALT);
    assign bus.fault     = (state == ST_FAULT);

endmodule
